// File: rtl/serial_adder_if.sv
// Handshake and operand bus for the bit-serial adder.
// The controller (master) drives start/a/b; the adder (slave) returns
// busy/done and the registered sum with its carry out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  s,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output s,
        output cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one bit per clock, LSB first, single carry
// flip-flop. Used by the recursive Fibonacci datapath to add fib(n-1) and
// fib(n-2) on the way back up the recursion.
//
// Sequencing: IDLE -> ADD (WIDTH cycles) -> DONE (one cycle) -> IDLE, with a
// start seen in DONE accepted immediately so additions can run back to back
// at one result every WIDTH+1 cycles. The sum is shifted in at the MSB so it
// is aligned after the last bit without any final reordering.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the final bit; the counter never advances past this value.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Full-adder carry for one bit position.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    wire w_bit;
    wire w_carry_nxt;
    wire w_last;
    wire w_accept;

    // Current bit of the sum and the carry it produces.
    assign w_bit       = r_ra[0] ^ r_rb[0] ^ r_carry;
    assign w_carry_nxt = maj3(r_ra[0], r_rb[0], r_carry);
    assign w_last      = (r_cnt == LAST_CNT);

    // A start is honoured in every state except ADD; DONE accepts it for
    // back-to-back operation and any stray encoding behaves like IDLE.
    assign w_accept    = bus.start && (r_state != S_ADD);

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;

    // Controller FSM and serial datapath with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Capture operands; the previous result is dropped here.
            r_state <= S_ADD;
            r_ra    <= bus.a;
            r_rb    <= bus.b;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_ADD: begin
                    r_s     <= {w_bit, r_s[WIDTH-1:1]};
                    r_ra    <= {1'b0, r_ra[WIDTH-1:1]};
                    r_rb    <= {1'b0, r_rb[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    if (w_last) begin
                        r_cout  <= w_carry_nxt;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Result stays on s/cout; done is a single-cycle pulse.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake scenarios plus
// random operands, each result compared with plain integer addition.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(
        .WIDTH(W),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge for drive and sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one addition; if ign_cycle is non-zero, pulse start with other
    // operands during that busy cycle (must be ignored).
    task automatic add_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int ign_cycle, output logic [W-1:0] res);
        logic [W:0] exp_sum;
        exp_sum = {1'b0, x} + {1'b0, y};
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        tick();
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        for (int c = 1; c <= W; c++) begin
            chk("busy_in_add", 32'(bus.busy), 1);
            chk("no_early_done", 32'(bus.done), 0);
            bus.start = (c == ign_cycle);
            if (c == ign_cycle) begin
                bus.a = 8'd1;
                bus.b = 8'd1;
            end
            tick();
        end
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 1);
        chk("busy_in_done", 32'(bus.busy), 0);
        chk("sum", 32'(bus.s), 32'(exp_sum[W-1:0]));
        chk("cout", 32'(bus.cout), 32'(exp_sum[W]));
        tick();
        chk("done_single", 32'(bus.done), 0);
        chk("busy_after", 32'(bus.busy), 0);
        chk("sum_hold", 32'(bus.s), 32'(exp_sum[W-1:0]));
        chk("cout_hold", 32'(bus.cout), 32'(exp_sum[W]));
        res = exp_sum[W-1:0];
    endtask

    // Hard stop if something wedges the sequence below.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] fx;
        logic [W-1:0] fy;
        logic [W:0]   e1;
        logic [W:0]   e2;
        int           seen;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        rst = 1'b0;
        tick();

        // Directed operand patterns.
        add_op(8'd3, 8'd5, 0, r);
        add_op(8'd200, 8'd100, 0, r);
        add_op(8'd255, 8'd1, 0, r);
        add_op(8'd0, 8'd0, 0, r);

        // Start while busy is ignored.
        add_op(8'd13, 8'd21, 3, r);
        chk("ignored_start_s", 32'(r), 34);
        tick();
        chk("ignored_start_idle", 32'(bus.busy), 0);

        // Back-to-back with start held high.
        e1 = 9'd8 + 9'd13;
        e2 = 9'd21 + 9'd34;
        bus.start = 1'b1;
        bus.a = 8'd8;
        bus.b = 8'd13;
        tick();
        bus.a = 8'd21;
        bus.b = 8'd34;
        for (int c = 1; c <= W; c++) begin
            chk("b2b_busy1", 32'(bus.busy), 1);
            tick();
        end
        chk("b2b_done1", 32'(bus.done), 1);
        chk("b2b_s1", 32'(bus.s), 32'(e1[W-1:0]));
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= W; c++) begin
            chk("b2b_busy2", 32'(bus.busy), 1);
            chk("b2b_nodone2", 32'(bus.done), 0);
            tick();
        end
        chk("b2b_done2", 32'(bus.done), 1);
        chk("b2b_s2", 32'(bus.s), 32'(e2[W-1:0]));
        tick();
        chk("b2b_done2_single", 32'(bus.done), 0);

        // Fibonacci chain up to the overflowing 144+233.
        fx = 8'd0;
        fy = 8'd1;
        for (int i = 0; i < 13; i++) begin
            add_op(fx, fy, 0, r);
            fx = fy;
            fy = r;
        end
        chk("fib_wrap_s", 32'(bus.s), 121);
        chk("fib_wrap_cout", 32'(bus.cout), 1);

        // Reset in the middle of an addition.
        bus.start = 1'b1;
        bus.a = 8'd250;
        bus.b = 8'd250;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_s", 32'(bus.s), 0);
        chk("midrst_cout", 32'(bus.cout), 0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        chk("midrst_no_done", 32'(seen), 0);
        add_op(8'd77, 8'd99, 0, r);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            add_op(W'($urandom), W'($urandom), 0, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
